// File: rtl/vga_pkg.sv
// vga_pkg: video timing constants and lock state shared by the VGA sync monitor
package vga_pkg;
  localparam int VGA_CNT_W = 12;
  localparam int VGA640_HS_A = 96;
  localparam int VGA640_HS_B = 48;
  localparam int VGA640_HS_C = 640;
  localparam int VGA640_HS_E = 800;
  localparam int VGA640_VS_A = 2;
  localparam int VGA640_VS_B = 33;
  localparam int VGA640_VS_C = 480;
  localparam int VGA640_VS_E = 525;
  typedef enum logic {SEARCH, LOCKED} lock_state_t;
endpackage

// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: VGA output bus (active-low syncs, RGB332 pixel)
interface vga_sync_monitor_if;
  logic       vga_hs;
  logic       vga_vs;
  logic [7:0] vga_rgb;
  modport master (output vga_hs, vga_vs, vga_rgb);
  modport slave (input vga_hs, vga_vs, vga_rgb);
endinterface

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers one sync line and flags its falling/rising edges
module vga_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic fall,
  output logic rise
);
  logic q_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b1;
      q_d <= 1'b1;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end
  assign fall = q_d & ~q;
  assign rise = ~q_d & q;
endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures VGA sync timing, checksums the active window and
// reports lock once consecutive frames match the configured standard
module vga_sync_monitor import vga_pkg::*; #(
  parameter int HS_A        = VGA640_HS_A,
  parameter int HS_B        = VGA640_HS_B,
  parameter int HS_C        = VGA640_HS_C,
  parameter int HS_E        = VGA640_HS_E,
  parameter int VS_A        = VGA640_VS_A,
  parameter int VS_B        = VGA640_VS_B,
  parameter int VS_C        = VGA640_VS_C,
  parameter int VS_E        = VGA640_VS_E,
  parameter int CNT_W       = VGA_CNT_W,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_sync_monitor_if.slave    vga,
  output logic                 meas_valid,
  output logic [CNT_W-1:0]     h_total,
  output logic [CNT_W-1:0]     h_sync_w,
  output logic [CNT_W-1:0]     v_total,
  output logic [CNT_W-1:0]     v_sync_w,
  output logic [31:0]          frame_sum,
  output logic                 frame_err,
  output logic                 locked
);
  localparam int TO   = 2 * VS_E * HS_E;
  localparam int TO_W = $clog2(TO);
  localparam logic [CNT_W-1:0] X_LO = CNT_W'(HS_A + HS_B);
  localparam logic [CNT_W-1:0] X_HI = CNT_W'(HS_A + HS_B + HS_C - 1);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'(VS_A + VS_B);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(VS_A + VS_B + VS_C - 1);
  logic hs_q, hs_fall, hs_rise, vs_q, vs_fall, vs_rise;
  logic [7:0] rgb_q, rgb_d;
  logic [CNT_W-1:0] x, y, x_inc, y_end, h_total_line, hs_low_cnt, h_sync_line, vs_line_cnt, v_sync_line;
  logic [TO_W-1:0] to_cnt;
  logic [31:0] sum;
  logic frame_pend, hs_seen, frame_seen, line_bad, x_sat;
  logic x_max, y_max, line_chk, in_win, frame_end, timeout;
  lock_state_t state;
  logic [3:0] good_cnt, good_nxt;
  vga_edge_det u_hs (.clk(clk), .rst_n(rst_n), .din(vga.vga_hs), .q(hs_q), .fall(hs_fall), .rise(hs_rise));
  vga_edge_det u_vs (.clk(clk), .rst_n(rst_n), .din(vga.vga_vs), .q(vs_q), .fall(vs_fall), .rise(vs_rise));
  always_comb begin
    x_max     = &x;
    y_max     = &y;
    x_inc     = x + 1'b1;
    y_end     = y + 1'b1;
    line_chk  = hs_fall & hs_seen & (x_inc != CNT_W'(HS_E));
    in_win    = (x >= X_LO) && (x <= X_HI) && (y >= Y_LO) && (y <= Y_HI);
    frame_end = vs_fall & frame_seen;
    timeout   = to_cnt == TO_W'(TO - 1);
    good_nxt  = good_cnt + 4'd1;
  end
  // rgb gets a second stage so the pixel lines up with x, which resets a cycle after the hs edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      rgb_d <= '0;
      x <= '0;
      y <= '0;
      h_total_line <= '0;
      hs_low_cnt <= '0;
      h_sync_line <= '0;
      vs_line_cnt <= '0;
      v_sync_line <= '0;
      to_cnt <= '0;
      sum <= '0;
      frame_pend <= 1'b0;
      hs_seen <= 1'b0;
      frame_seen <= 1'b0;
      line_bad <= 1'b0;
      x_sat <= 1'b0;
      meas_valid <= 1'b0;
      frame_err <= 1'b0;
      h_total <= '0;
      h_sync_w <= '0;
      v_total <= '0;
      v_sync_w <= '0;
      frame_sum <= '0;
    end else begin
      rgb_q <= vga.vga_rgb;
      rgb_d <= rgb_q;
      x <= hs_fall ? '0 : x_max ? x : x_inc;
      if (hs_fall) begin
        h_total_line <= x_inc;
        hs_seen <= 1'b1;
        y <= (frame_pend | vs_fall) ? '0 : y_max ? y : y_end;
      end
      frame_pend <= hs_fall ? 1'b0 : (frame_pend | vs_fall);
      hs_low_cnt <= hs_rise ? '0 : hs_low_cnt + CNT_W'(!hs_q);
      if (hs_rise) h_sync_line <= hs_low_cnt;
      vs_line_cnt <= vs_fall ? CNT_W'(hs_fall) : vs_line_cnt + CNT_W'(hs_fall & !vs_q);
      if (vs_rise) v_sync_line <= vs_line_cnt;
      to_cnt <= (vs_fall | timeout) ? '0 : to_cnt + 1'b1;
      frame_seen <= !timeout & (frame_seen | vs_fall);
      meas_valid <= frame_end;
      frame_err <= frame_end & (line_bad | line_chk | x_sat | x_max | (y_end != CNT_W'(VS_E)));
      if (frame_end) begin
        h_total <= h_total_line;
        h_sync_w <= h_sync_line;
        v_total <= y_end;
        v_sync_w <= v_sync_line;
        frame_sum <= sum;
      end
      sum <= vs_fall ? '0 : sum + (in_win ? 32'(rgb_d) : 32'd0);
      line_bad <= !vs_fall & (line_bad | line_chk);
      x_sat <= !vs_fall & (x_sat | x_max);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      good_cnt <= '0;
      locked <= 1'b0;
    end else if (timeout || (meas_valid && frame_err)) begin
      state <= SEARCH;
      good_cnt <= '0;
      locked <= 1'b0;
    end else if (meas_valid && state == SEARCH) begin
      good_cnt <= good_nxt;
      if (good_nxt == 4'(LOCK_FRAMES)) begin
        state <= LOCKED;
        locked <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of the sync monitor on a scaled-down
// 16x8 video mode (28 clocks/line, 16 lines/frame) to keep runs short
module tb_vga_sync_monitor;
  localparam int HA = 4, HB = 4, HC = 16, HE = 28;
  localparam int VA = 2, VB = 3, VC = 8, VE = 16;
  localparam int TO = 2 * VE * HE;
  localparam int CHESS_SUM = 16320, RAMP_SUM = 8128, ONES_SUM = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas_valid, frame_err, locked;
  logic [11:0] h_total, h_sync_w, v_total, v_sync_w;
  logic [31:0] frame_sum;
  int checks = 0, failures = 0, mv_cnt = 0, fe_cnt = 0, mv_mark = 0;
  logic [11:0] c_ht = '0, c_hs = '0, c_vt = '0, c_vs = '0;
  logic [31:0] c_sum = '0;
  logic c_err = 1'b0;
  vga_sync_monitor_if vga ();
  vga_sync_monitor #(
    .HS_A(HA), .HS_B(HB), .HS_C(HC), .HS_E(HE),
    .VS_A(VA), .VS_B(VB), .VS_C(VC), .VS_E(VE),
    .CNT_W(12), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga(vga),
    .meas_valid(meas_valid), .h_total(h_total), .h_sync_w(h_sync_w),
    .v_total(v_total), .v_sync_w(v_sync_w), .frame_sum(frame_sum),
    .frame_err(frame_err), .locked(locked)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (meas_valid) begin
      mv_cnt <= mv_cnt + 1;
      c_ht <= h_total;
      c_hs <= h_sync_w;
      c_vt <= v_total;
      c_vs <= v_sync_w;
      c_sum <= frame_sum;
      c_err <= frame_err;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_meas_valid"}, 32'(meas_valid), 0);
    check({tag, "_h_total"}, 32'(h_total), 0);
    check({tag, "_h_sync_w"}, 32'(h_sync_w), 0);
    check({tag, "_v_total"}, 32'(v_total), 0);
    check({tag, "_v_sync_w"}, 32'(v_sync_w), 0);
    check({tag, "_frame_sum"}, frame_sum, 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_locked"}, 32'(locked), 0);
  endtask
  // pat: 0 = 4-px chessboard 0xFF/0x00, 1 = all 0x01, 2 = ramp 0..127
  task automatic set_pix(input int l, input int p, input int pat);
    int px, ly;
    px = p - (HA + HB);
    ly = l - (VA + VB);
    vga.vga_hs = (p >= HA);
    vga.vga_vs = (l >= VA);
    if (px >= 0 && px < HC && ly >= 0 && ly < VC)
      vga.vga_rgb = (pat == 0) ? ((((px / 4) + (ly / 4)) % 2 == 0) ? 8'hFF : 8'h00) :
                    (pat == 1) ? 8'h01 : 8'(ly * 16 + px);
    else
      vga.vga_rgb = 8'h00;
  endtask
  task automatic frame(input int pat, input int lines = VE, input int bad = -1);
    for (int l = 0; l < lines; l++)
      for (int p = 0; p < ((l == bad) ? HE + 1 : HE); p++) begin
        @(negedge clk);
        set_pix(l, p, pat);
      end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vga.vga_hs = 1'b1;
      vga.vga_vs = 1'b1;
      vga.vga_rgb = 8'h00;
    end
  endtask
  initial begin
    vga.vga_hs = 1'b1;
    vga.vga_vs = 1'b1;
    vga.vga_rgb = 8'h00;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    frame(0);
    check("arm_no_meas", mv_cnt, 0);
    frame(0);
    check("f2_meas_cnt", mv_cnt, 1);
    check("f2_h_total", c_ht, HE);
    check("f2_h_sync_w", c_hs, HA);
    check("f2_v_total", c_vt, VE);
    check("f2_v_sync_w", c_vs, VA);
    check("f2_sum_chess", c_sum, CHESS_SUM);
    check("f2_err", c_err, 0);
    check("f2_locked", locked, 0);
    frame(0);
    check("f3_meas_cnt", mv_cnt, 2);
    check("f3_sum_chess", c_sum, CHESS_SUM);
    check("f3_locked", locked, 1);
    frame(2);
    frame(1);
    check("ramp_sum", c_sum, RAMP_SUM);
    check("ramp_locked", locked, 1);
    frame(0, VE, 10);
    check("ones_sum", c_sum, ONES_SUM);
    check("ones_err", c_err, 0);
    check("ones_locked", locked, 1);
    frame(0);
    check("long_line_meas_cnt", mv_cnt, 6);
    check("long_line_err", c_err, 1);
    check("long_line_h_total", c_ht, HE);
    check("long_line_unlock", locked, 0);
    frame(0);
    check("relock1_err", c_err, 0);
    check("relock1_locked", locked, 0);
    frame(0);
    check("relock2_locked", locked, 1);
    frame(0, VE - 1);
    frame(0);
    check("short_v_total", c_vt, VE - 1);
    check("short_err", c_err, 1);
    check("short_locked", locked, 0);
    frame(0);
    check("short_next_locked", locked, 0);
    frame(0);
    check("pre_timeout_locked", locked, 1);
    mv_mark = mv_cnt;
    idle(TO);
    check("timeout_unlock", locked, 0);
    check("timeout_no_meas", mv_cnt, mv_mark);
    frame(0);
    check("timeout_arm_no_meas", mv_cnt, mv_mark);
    frame(0);
    check("timeout_good1_meas", mv_cnt, mv_mark + 1);
    check("timeout_good1_locked", locked, 0);
    frame(0);
    check("timeout_relock", locked, 1);
    for (int l = 0; l < 7; l++)
      for (int p = 0; p < HE; p++) begin
        @(negedge clk);
        set_pix(l, p, 0);
      end
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      set_pix(7, p, 0);
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    mv_mark = mv_cnt;
    frame(0);
    check("post_rst_arm_no_meas", mv_cnt, mv_mark);
    check("post_rst_h_total", h_total, 0);
    frame(0);
    check("post_rst_meas_cnt", mv_cnt, mv_mark + 1);
    check("post_rst_h_total_meas", c_ht, HE);
    check("post_rst_v_total", c_vt, VE);
    check("post_rst_sum", c_sum, CHESS_SUM);
    check("post_rst_locked", locked, 0);
    check("err_pulse_total", fe_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
